muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
//
// PURPOSE
// - Iterative RV32M multiply/divide unit. Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on DATA_WIDTH operands.
// - Sits beside the single-cycle ALU in the execute stage. The control unit asserts start for op=0110011 with funct7=0000001.
// - The hazard unit stalls the pipeline while busy=1. It is the first multi-cycle execute resource; a ready/valid handshake on the result side.
//
// PARAMETERS
// - DATA_WIDTH    32  operand/result width; must be even and >=4
// - FUNCT3_WIDTH  3   width of the M-extension op select
//
// PORTS
// - clk           in   1             rising-edge clock
// - rst           in   1             synchronous, active-high reset
// - start         in   1             request; sampled only in IDLE
// - flush         in   1             kill in-flight op (branch mispredict / trap)
// - funct3        in   FUNCT3_WIDTH  M-ext op: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
// - srcA          in   DATA_WIDTH    rs1 (multiplicand / dividend)
// - srcB          in   DATA_WIDTH    rs2 (multiplier / divisor)
// - busy          out  1             1 in any state except IDLE
// - result_valid  out  1             1 in DONE only
// - result_ready  in   1             consumer accepts result
// - result        out  DATA_WIDTH    op result; held stable while result_valid=1
//
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, result_valid=0, result=0; all internal registers cleared.
// - States: IDLE, CALC, FIX, DONE.
// - IDLE, start=1: latch funct3, absolute values of signed operands, and the result sign.
//   - MULHSU: srcA is signed, srcB is unsigned.
//   - Normal path: count=0, go to CALC.
// - Special cases in IDLE go straight to FIX with the preset result:
//   - divisor==0: DIV/DIVU give all ones; REM/REMU give srcA.
//   - Signed overflow (srcA = 1<<(W-1), srcB = all ones, DIV/REM): DIV gives srcA; REM gives 0.
// - CALC: one bit per cycle for exactly DATA_WIDTH cycles; count wraps to 0, then go to FIX.
//   - Multiply: shift-add into a 2*W accumulator.
//   - Divide: restoring; remainder W+1 bits, quotient W bits.
// - FIX (1 cycle): apply two's-complement negation if the sign flag is set. Select the result:
//   - MUL: low W bits; MULH*: high W bits.
//   - DIV*: quotient; REM*: remainder. Remainder sign = dividend sign.
// - DONE: result_valid=1. Go to IDLE on the cycle result_valid & result_ready; start is ignored in DONE.
// - Latency:
//   - Normal: result_valid is first high W+2 edges after the accepting edge (CALC W, FIX 1, enter DONE).
//   - Special cases: 2 edges.
// - Back-to-back: a new start is sampled in IDLE only, so there is at least 1 idle cycle between ops.
// - flush=1 in CALC/FIX/DONE: next state IDLE, result_valid=0, no result delivered.
//   - flush in IDLE: start is ignored that cycle.
//   - flush has priority over result_ready.
// - rst mid-operation: identical to reset; the in-flight op is discarded.
// - All arithmetic is in W or 2*W bits with explicit zero/sign extension. Overflow wraps silently (RISC-V semantics, no trap).
//
// STRUCTURE
// - muldiv_pkg holds:
//   - typedef enum logic [2:0] for the M-ext ops (MD_MUL..MD_REMU).
//   - typedef enum logic [1:0] for states (MD_IDLE, MD_CALC, MD_FIX, MD_DONE).
//   - helper constant function clog2-based COUNT_WIDTH.
// - One sub-module: muldiv_negate, a combinational conditional two's-complement of width N. It is instantiated for operand abs and result fix.
// - FSM and datapath stay in one file.
//
// TESTING
// - MUL 7 * -3 (srcB=32'hFFFF_FFFD) -> result=32'hFFFF_FFEB. result_valid rises 34 cycles after accept.
// - MULHU FFFF_FFFF * FFFF_FFFF -> 32'hFFFF_FFFE. MULH same operands -> 32'h0000_0000. MULHSU same -> 32'hFFFF_FFFF.
// - DIV -7 / 2 -> 32'hFFFF_FFFD. REM -7 / 2 -> 32'hFFFF_FFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
// - DIV x / 0 -> FFFF_FFFF and REM 5 / 0 -> 5, both in 2 cycles. DIV 8000_0000 / FFFF_FFFF -> 8000_0000. REM same -> 0.
// - Hold result_ready=0 for 5 cycles in DONE: result stable, busy=1, start ignored. Release: IDLE next cycle.
// - flush at CALC cycle 10, then rst during a second op: no result_valid pulse, IDLE next edge, busy=0.
//   - A following MUL 3 * 4 returns 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   // M-extension operation select (funct3 encoding)
   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   // Control FSM states
   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_FIX,
      MD_DONE
   } md_state_e;

   // Width of the iteration counter that runs 0 .. width-1
   function automatic int unsigned count_width(input int unsigned width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of an N-bit value.
module muldiv_negate #(
   parameter int unsigned N = 32
) (
   input  logic         neg,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   // Pass through, or invert and add one when neg is set
   always_comb begin
      dout = din;
      if (neg) begin
         dout = ~din + N'(1);
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, sign fix-up in a final cycle, ready/valid result.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned FUNCT3_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    flush,
   input  logic [FUNCT3_WIDTH-1:0] funct3,
   input  logic [DATA_WIDTH-1:0]   srcA,
   input  logic [DATA_WIDTH-1:0]   srcB,
   output logic                    busy,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [DATA_WIDTH-1:0]   result
);

   localparam int unsigned W          = DATA_WIDTH;
   localparam int unsigned CW         = count_width(W);
   localparam logic [CW-1:0] COUNT_LAST = CW'(W - 1);
   localparam logic [W-1:0]  INT_MIN    = {1'b1, {(W-1){1'b0}}};

   md_state_e       state_q, state_d;
   md_op_e          op_q, op_d;
   logic            neg_q, neg_d;
   logic            special_q, special_d;
   logic [CW-1:0]   count_q, count_d;
   // Multiplicand (multiply) or divisor magnitude (divide)
   logic [W-1:0]    opnd_q, opnd_d;
   // Multiply: 2W product/multiplier shifter. Divide: {remainder, quotient/dividend}.
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    result_q, result_d;

   // Incoming operation decode
   md_op_e          in_op;
   logic            in_is_div, in_is_rem;
   logic            a_signed, b_signed, sign_a, sign_b;
   logic [W-1:0]    abs_a, abs_b;
   logic            div_by_zero, div_ovf;
   logic [W-1:0]    special_res;

   assign in_op     = md_op_e'(funct3[2:0]);
   assign in_is_div = funct3[2];
   assign in_is_rem = funct3[2] & funct3[1];
   assign a_signed  = (in_op == MD_MULH) || (in_op == MD_MULHSU) ||
                      (in_op == MD_DIV) || (in_op == MD_REM);
   assign b_signed  = (in_op == MD_MULH) || (in_op == MD_DIV) || (in_op == MD_REM);
   assign sign_a    = a_signed & srcA[W-1];
   assign sign_b    = b_signed & srcB[W-1];

   muldiv_negate #(.N(W)) u_abs_a (
      .neg  (sign_a),
      .din  (srcA),
      .dout (abs_a)
   );

   muldiv_negate #(.N(W)) u_abs_b (
      .neg  (sign_b),
      .din  (srcB),
      .dout (abs_b)
   );

   assign div_by_zero = in_is_div && (srcB == '0);
   assign div_ovf     = ((in_op == MD_DIV) || (in_op == MD_REM)) &&
                        (srcA == INT_MIN) && (srcB == '1);

   // Preset result for divide-by-zero and signed overflow
   always_comb begin
      special_res = '0;
      if (div_by_zero) begin
         special_res = funct3[1] ? srcA : '1;
      end else if (div_ovf) begin
         special_res = funct3[1] ? '0 : srcA;
      end
   end

   // One iteration of the multiply and divide datapaths
   logic [W:0]     mul_sum;
   logic [W:0]     div_shift;
   logic           div_ok;
   logic [W-1:0]   div_rem;
   logic [2*W-1:0] mul_step, div_step;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_step  = {mul_sum, acc_q[W-1:1]};
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_ok    = (div_shift >= {1'b0, opnd_q});
      // Partial remainder always fits in W bits once the divisor is subtracted
      div_rem   = div_ok ? (div_shift[W-1:0] - opnd_q) : div_shift[W-1:0];
      div_step  = {div_rem, acc_q[W-2:0], div_ok};
   end

   // Final sign fix-up and result select
   logic [2*W-1:0] fix_in, fix_out;
   logic [W-1:0]   fix_res;

   always_comb begin
      fix_in = acc_q;
      if (op_q[2]) begin
         fix_in = {{W{1'b0}}, (op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0])};
      end
   end

   muldiv_negate #(.N(2*W)) u_fix (
      .neg  (neg_q),
      .din  (fix_in),
      .dout (fix_out)
   );

   assign fix_res = ((op_q == MD_MUL) || op_q[2]) ? fix_out[W-1:0] : fix_out[2*W-1:W];

   // Next-state and datapath next values
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      special_d = special_q;
      count_d   = count_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      result_d  = result_q;
      unique case (state_q)
         MD_IDLE: begin
            if (start && !flush) begin
               op_d    = in_op;
               // Remainder takes the dividend's sign; everything else the product of signs
               neg_d   = in_is_rem ? sign_a : (sign_a ^ sign_b);
               count_d = '0;
               if (in_is_div) begin
                  opnd_d = abs_b;
                  acc_d  = {{W{1'b0}}, abs_a};
               end else begin
                  opnd_d = abs_a;
                  acc_d  = {{W{1'b0}}, abs_b};
               end
               if (div_by_zero || div_ovf) begin
                  special_d = 1'b1;
                  result_d  = special_res;
                  state_d   = MD_FIX;
               end else begin
                  special_d = 1'b0;
                  state_d   = MD_CALC;
               end
            end
         end
         MD_CALC: begin
            if (flush) begin
               state_d = MD_IDLE;
            end else begin
               acc_d   = op_q[2] ? div_step : mul_step;
               count_d = count_q + CW'(1);
               if (count_q == COUNT_LAST) begin
                  count_d = '0;
                  state_d = MD_FIX;
               end
            end
         end
         MD_FIX: begin
            if (flush) begin
               state_d = MD_IDLE;
            end else begin
               if (!special_q) begin
                  result_d = fix_res;
               end
               state_d = MD_DONE;
            end
         end
         MD_DONE: begin
            if (flush || result_ready) begin
               state_d = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MD_IDLE;
         op_q      <= MD_MUL;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         count_q   <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         special_q <= special_d;
         count_q   <= count_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
      end
   end

   assign busy         = (state_q != MD_IDLE);
   assign result_valid = (state_q == MD_DONE);
   assign result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit with hand-written corner sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic        busy;
   logic        result_valid;
   logic        result_ready = 1'b1;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_unit #(
      .DATA_WIDTH   (32),
      .FUNCT3_WIDTH (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .flush        (flush),
      .funct3       (funct3),
      .srcA         (srcA),
      .srcB         (srcB),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NVEC = 22;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one op from IDLE, count edges (accepting edge = 1) until result_valid
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_exp, input string tag);
      int   lat;
      logic ok;
      lat = 0;
      ok  = 1'b0;
      @(posedge clk);
      #1;
      funct3 = f3;
      srcA   = a;
      srcB   = b;
      start  = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            check({tag, "_busy"}, {31'b0, busy}, 32'd1);
         end
         if (result_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_timeout"}, {31'b0, ok}, 32'd1);
      check({tag, "_lat"}, lat, lat_exp);
      check({tag, "_res"}, result, exp);
   endtask

   initial begin
      int vcount;

      vecs[0]  = '{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34}; // MUL
      vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34}; // MULHU
      vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34}; // MULH
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34}; // MULHSU
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34}; // DIV -7/2
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34}; // REM -7/2
      vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,        34}; // DIVU
      vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,         34}; // REMU
      vecs[8]  = '{3'b100, 32'h0000_1234, 32'd0,       32'hFFFF_FFFF, 2};  // DIV by 0
      vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,         2};  // REM by 0
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2}; // DIV ovf
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2}; // REM ovf
      vecs[12] = '{3'b000, 32'd3,        32'd4,        32'd12,        34}; // MUL
      vecs[13] = '{3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 2};  // DIVU by 0
      vecs[14] = '{3'b111, 32'hDEAD_BEEF, 32'd0,       32'hDEAD_BEEF, 2};  // REMU by 0
      vecs[15] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34}; // MUL low
      vecs[16] = '{3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34}; // DIV 7/-2
      vecs[17] = '{3'b110, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 34}; // REM 7/-2
      vecs[18] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34}; // MULH min*min
      vecs[19] = '{3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 34}; // DIVU /1
      vecs[20] = '{3'b111, 32'h8000_0000, 32'd3,        32'd2,         34}; // REMU
      vecs[21] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        34}; // DIVU no ovf

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_valid", {31'b0, result_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                $sformatf("vec%0d", i));
      end

      // Hold result in DONE with result_ready low; start must be ignored
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      run_op(3'b000, 32'd6, 32'd7, 32'd42, 34, "hold");
      for (int i = 0; i < 5; i++) begin
         start  = 1'b1;
         funct3 = 3'b100;
         srcA   = 32'd100 + i;
         srcB   = 32'd0;
         @(posedge clk);
         #1;
         check($sformatf("hold%0d_res", i), result, 32'd42);
         check($sformatf("hold%0d_busy", i), {31'b0, busy}, 32'd1);
         check($sformatf("hold%0d_valid", i), {31'b0, result_valid}, 32'd1);
      end
      start        = 1'b0;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_busy", {31'b0, busy}, 32'd0);
      check("release_valid", {31'b0, result_valid}, 32'd0);

      // start together with flush in IDLE is ignored
      @(posedge clk);
      #1;
      start  = 1'b1;
      flush  = 1'b1;
      funct3 = 3'b000;
      srcA   = 32'd9;
      srcB   = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("idle_flush_busy", {31'b0, busy}, 32'd0);

      // Flush in the middle of CALC
      @(posedge clk);
      #1;
      funct3 = 3'b000;
      srcA   = 32'h0000_1234;
      srcB   = 32'h0000_5678;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("calc_busy", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_valid", {31'b0, result_valid}, 32'd0);
      vcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (result_valid || busy) vcount++;
      end
      check("flush_no_result", vcount, 32'd0);
      check("flush_result_kept", result, 32'd42);

      // Reset in the middle of a second op
      funct3 = 3'b101;
      srcA   = 32'd100;
      srcB   = 32'd7;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_valid", {31'b0, result_valid}, 32'd0);
      check("midrst_result", result, 32'd0);
      vcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (result_valid || busy) vcount++;
      end
      check("midrst_no_result", vcount, 32'd0);

      run_op(3'b000, 32'd3, 32'd4, 32'd12, 34, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
